// File: rtl/stack_alu_ctrl.sv
// stack_alu_ctrl: executes one binary op (b OP a) on the top two stack
// entries and hands the result back to the stack through a pop_alu strobe.
// Optional feature macro: STACK_ALU_MULDIV_EN builds the iterative
// multiply/divide datapath. Without it, ops 6/7 report an illegal op.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for op_valid; op_ready high once out of reset
// S_ITER | 32 shift-add / restoring-divide iterations (muldiv build)
// S_WB   | pop_alu high for one cycle with result
// S_ERR  | error high for one cycle, no writeback
module stack_alu_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  output logic        op_ready,
  input  logic [4:0]  depth,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        pop_alu,
  output logic [31:0] result,
  output logic        busy,
  output logic        error,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_WB, S_ERR} state_t;

  localparam logic [1:0] EC_NONE      = 2'd0;
  localparam logic [1:0] EC_UNDERFLOW = 2'd1;
  localparam logic [1:0] EC_DIVZERO   = 2'd2;
  localparam logic [1:0] EC_ILLEGAL   = 2'd3;

  state_t      state;
  logic        accept;
  logic [31:0] alu_out;

  assign accept = op_valid & op_ready;

  // Single-cycle ops evaluated straight from the operands at the accept edge.
  always_comb begin
    alu_out = '0;
    case (op_code)
      3'd0:    alu_out = operand_b + operand_a;
      3'd1:    alu_out = operand_b - operand_a;
      3'd2:    alu_out = operand_b & operand_a;
      3'd3:    alu_out = operand_b | operand_a;
      3'd4:    alu_out = operand_b ^ operand_a;
      3'd5:    alu_out = {31'd0, $signed(operand_b) < $signed(operand_a)};
      default: alu_out = '0;
    endcase
  end

`ifdef STACK_ALU_MULDIV_EN
  // it_a: multiplicand (mul) or divisor (div)
  // it_b: multiplier shifted right (mul) or dividend/quotient shifted left (div)
  // it_acc: product accumulator (mul) or partial remainder (div)
  logic [31:0] it_a, it_b, it_acc;
  logic        it_div;
  logic [4:0]  it_cnt;
  logic [31:0] it_a_nxt, it_b_nxt, it_acc_nxt;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;

  // One iteration of either the shift-add multiply or the restoring divide.
  always_comb begin
    div_shift  = {it_acc, it_b[31]};
    div_ge     = div_shift >= {1'b0, it_a};
    div_diff   = div_shift - {1'b0, it_a};
    it_a_nxt   = it_a;
    it_b_nxt   = it_b;
    it_acc_nxt = it_acc;
    if (it_div) begin
      it_acc_nxt = div_ge ? div_diff[31:0] : div_shift[31:0];
      it_b_nxt   = {it_b[30:0], div_ge};
    end else begin
      it_acc_nxt = it_acc + (it_b[0] ? it_a : 32'd0);
      it_a_nxt   = {it_a[30:0], 1'b0};
      it_b_nxt   = {1'b0, it_b[31:1]};
    end
  end
`endif

  // Controller FSM with registered outputs; a reset drops any op in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op_ready <= 1'b0;
      pop_alu  <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      error    <= 1'b0;
      err_code <= EC_NONE;
`ifdef STACK_ALU_MULDIV_EN
      it_a     <= '0;
      it_b     <= '0;
      it_acc   <= '0;
      it_div   <= 1'b0;
      it_cnt   <= '0;
`endif
    end else begin
      pop_alu <= 1'b0;
      error   <= 1'b0;
      result  <= '0;
      case (state)
        S_IDLE: begin
          op_ready <= 1'b1;
          busy     <= 1'b0;
          if (accept) begin
            op_ready <= 1'b0;
            busy     <= 1'b1;
            err_code <= EC_NONE;
            if (depth < 5'd2) begin
              state    <= S_ERR;
              error    <= 1'b1;
              err_code <= EC_UNDERFLOW;
            end else if (op_code[2:1] == 2'b11) begin
`ifdef STACK_ALU_MULDIV_EN
              if (op_code[0] && (operand_a == 32'd0)) begin
                // Divide by zero still writes back, with an all-ones result.
                state    <= S_WB;
                pop_alu  <= 1'b1;
                result   <= '1;
                error    <= 1'b1;
                err_code <= EC_DIVZERO;
              end else begin
                state  <= S_ITER;
                it_div <= op_code[0];
                it_a   <= op_code[0] ? operand_a : operand_b;
                it_b   <= op_code[0] ? operand_b : operand_a;
                it_acc <= '0;
                it_cnt <= 5'd31;
              end
`else
              state    <= S_ERR;
              error    <= 1'b1;
              err_code <= EC_ILLEGAL;
`endif
            end else begin
              state   <= S_WB;
              pop_alu <= 1'b1;
              result  <= alu_out;
            end
          end
        end
        S_ITER: begin
`ifdef STACK_ALU_MULDIV_EN
          it_a   <= it_a_nxt;
          it_b   <= it_b_nxt;
          it_acc <= it_acc_nxt;
          it_cnt <= it_cnt - 5'd1;
          if (it_cnt == 5'd0) begin
            state   <= S_WB;
            pop_alu <= 1'b1;
            result  <= it_div ? it_b_nxt : it_acc_nxt;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_WB, S_ERR: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_alu_ctrl.sv
// Directed bench for stack_alu_ctrl: stimulus pushes the expected writeback
// or error event into a queue at the accept edge; a monitor pops and
// compares whenever the DUT raises pop_alu or error.
module tb_stack_alu_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = '0;
  logic        op_ready;
  logic [4:0]  depth = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        pop_alu;
  logic [31:0] result;
  logic        busy;
  logic        error;
  logic [1:0]  err_code;

  stack_alu_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .op_ready  (op_ready),
    .depth     (depth),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .pop_alu   (pop_alu),
    .result    (result),
    .busy      (busy),
    .error     (error),
    .err_code  (err_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pop;
    logic [31:0] res;
    logic        err;
    logic [1:0]  ec;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   ncyc    = 0;
  int   pop_cnt = 0;

`ifdef STACK_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per pop_alu/error event.
  always @(negedge clock) begin
    exp_t e;
    ncyc++;
    if (pop_alu) pop_cnt++;
    if (pop_alu || error) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event pop_alu=%0b error=%0b result=%h", pop_alu, error, result);
      end else begin
        e = sb.pop_front();
        chk("pop_alu", 32'(pop_alu), 32'(e.pop));
        if (e.pop) chk("result", result, e.res);
        chk("error", 32'(error), 32'(e.err));
        chk("err_code", 32'(err_code), 32'(e.ec));
        chk("latency", 32'(ncyc - e.acc), 32'(e.lat));
        chk("busy_in_wb", 32'(busy), 32'd1);
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic ep, input logic [31:0] er,
                        input logic ee, input logic [1:0] ec, input int lat, input int hold);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clock); #1;
    while (!op_ready && n < 100) begin @(posedge clock); #1; n++; end
    chk("ready_wait", 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_code = op; operand_a = a; operand_b = b; depth = d;
    @(posedge clock); #1;
    e.pop = ep; e.res = er; e.err = ee; e.ec = ec; e.lat = lat; e.acc = ncyc;
    sb.push_back(e);
    repeat (hold) begin @(posedge clock); #1; end
    op_valid  = 1'b0;
    op_code   = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    depth     = 5'd0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clock); #1; n++; end
    chk("drain", 32'(sb.size()), 32'd0);
    chk("ready_after", 32'(op_ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("err_code_held", 32'(err_code), 32'(ec));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pops_before;
    exp_t e;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_pop_alu", 32'(pop_alu), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_release", 32'(op_ready), 32'd1);

    //      op  a             b             d   pop res           err ec lat hold
    run_op(3'd0, 32'd7,        32'd5,        5'd2, 1, 32'd12,        0, 0, 1, 1);
    run_op(3'd1, 32'd3,        32'hFFFFFFFE, 5'd2, 1, 32'hFFFFFFFB,  0, 0, 1, 0);
    run_op(3'd5, 32'd3,        32'hFFFFFFFE, 5'd3, 1, 32'd1,         0, 0, 1, 0);
    run_op(3'd5, 32'hFFFFFFFF, 32'd1,        5'd2, 1, 32'd0,         0, 0, 1, 0);
    run_op(3'd2, 32'hF0F01234, 32'h0FF0FF00, 5'd16,1, 32'h00F01200,  0, 0, 1, 0);
    run_op(3'd3, 32'h000000F0, 32'h00000F0F, 5'd2, 1, 32'h00000FFF,  0, 0, 1, 0);
    run_op(3'd4, 32'hFFFF0000, 32'h0F0F0F0F, 5'd2, 1, 32'hF0F00F0F,  0, 0, 1, 0);
    run_op(3'd0, 32'hFFFFFFFF, 32'd2,        5'd2, 1, 32'd1,         0, 0, 1, 0);
    run_op(3'd0, 32'd7,        32'd5,        5'd1, 0, 32'd0,         1, 1, 1, 0);
    run_op(3'd6, 32'd6,        32'd7,        5'd0, 0, 32'd0,         1, 1, 1, 0);

    if (MD) begin
      run_op(3'd6, 32'd6,        32'd7,        5'd2, 1, 32'd42,        0, 0, 33, 5);
      run_op(3'd6, 32'h00010000, 32'h00010000, 5'd2, 1, 32'd0,         0, 0, 33, 0);
      run_op(3'd6, 32'hFFFFFFFF, 32'd3,        5'd2, 1, 32'hFFFFFFFD,  0, 0, 33, 0);
      run_op(3'd7, 32'd7,        32'd100,      5'd2, 1, 32'd14,        0, 0, 33, 0);
      run_op(3'd7, 32'd100,      32'd7,        5'd2, 1, 32'd0,         0, 0, 33, 0);
      run_op(3'd7, 32'd1,        32'hFFFFFFFF, 5'd2, 1, 32'hFFFFFFFF,  0, 0, 33, 0);
      run_op(3'd7, 32'd0,        32'd55,       5'd2, 1, 32'hFFFFFFFF,  1, 2, 1, 0);
    end else begin
      run_op(3'd6, 32'd6,        32'd7,        5'd2, 0, 32'd0,         1, 3, 1, 0);
      run_op(3'd7, 32'd7,        32'd100,      5'd2, 0, 32'd0,         1, 3, 1, 0);
      run_op(3'd7, 32'd0,        32'd55,       5'd2, 0, 32'd0,         1, 3, 1, 0);
    end
    run_op(3'd1, 32'd1, 32'd1, 5'd2, 1, 32'd0, 0, 0, 1, 0);

    // Reset asserted ten cycles into a MUL.
    @(posedge clock); #1;
    op_valid = 1'b1; op_code = 3'd6; operand_a = 32'd6; operand_b = 32'd7; depth = 5'd2;
    @(posedge clock); #1;
    if (!MD) begin
      e.pop = 1'b0; e.res = '0; e.err = 1'b1; e.ec = 2'd3; e.lat = 1; e.acc = ncyc;
      sb.push_back(e);
    end
    op_valid = 1'b0;
    pops_before = pop_cnt;
    repeat (9) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("midop_rst_pop_alu", 32'(pop_alu), 32'd0);
    chk("midop_rst_busy", 32'(busy), 32'd0);
    chk("midop_rst_error", 32'(error), 32'd0);
    chk("midop_rst_result", result, 32'd0);
    chk("midop_rst_op_ready", 32'(op_ready), 32'd0);
    chk("midop_rst_err_code", 32'(err_code), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk("no_pop_after_rst", 32'(pop_cnt - pops_before), 32'd0);
    chk("sb_empty_after_rst", 32'(sb.size()), 32'd0);
    run_op(3'd0, 32'd7, 32'd5, 5'd2, 1, 32'd12, 0, 0, 1, 0);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_alu_ctrl.md
# stack_alu_ctrl

- Executes one binary operation on the top two stack entries and writes the result back.
- Sits on the ALU side of the operand stack: it reads the top (`operand_a`) and second (`operand_b`) entries, computes `b OP a`, then pulses `pop_alu` with `result`.
- In response to that pulse, the stack drops one entry and overwrites the new top with `result`.
- Single-cycle logic ops and optional iterative multiply/divide; underflow and divide-by-zero are flagged.

## Interface

- No parameters; data width fixed at 32, stack depth count fixed at 5 bits (0..16).
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  decoder presents an operation.
- `op_code`  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 MUL (low 32), 7 DIVU (quotient).
- `op_ready`  out  1  controller can accept an op.
- `depth`  in  5  current number of valid stack entries.
- `operand_a`  in  32  top of stack.
- `operand_b`  in  32  second entry.
- `pop_alu`  out  1  one-cycle writeback strobe to the stack.
- `result`  out  32  writeback value; valid only while `pop_alu`=1.
- `busy`  out  1  op in flight; upstream must not push/pop while high.
- `error`  out  1  one-cycle error pulse.
- `err_code`  out  2  0 none, 1 underflow, 2 div-by-zero, 3 illegal op; held until the next accepted op.

## Operation

- FSM states:
  - IDLE: `op_ready`=1, `busy`=0.
  - ITER: multiply/divide iterations.
  - WB: `pop_alu`=1 for one cycle.
  - ERR: `error`=1 for one cycle.
- Accept rule: the op is accepted at the edge where `op_valid`=1 and `op_ready`=1.
  - `op_code`, `operand_a` and `operand_b` are captured at that edge and never resampled.
  - `err_code` clears to 0 on accept.
- Underflow: `depth` < 2 at accept goes to ERR with `err_code`=1. No `pop_alu` is issued and the stack is unchanged.
- Ops 0–5 go directly to WB.
- ADD/SUB wrap modulo 2^32.
- SLT returns 1 if signed b < signed a, else 0.
- MUL (op 6): shift-add, 32 iterations in ITER, then WB; result is the low 32 bits of the product.
- DIVU (op 7): restoring divide, 32 iterations, then WB; result is the unsigned quotient b/a.
- Divide by zero (a=0): skips ITER and goes to WB.
  - `result`=0xFFFFFFFF and `pop_alu` still fires.
  - `error` pulses in the same cycle and `err_code`=2.
- WB and ERR always return to IDLE on the next edge.
- `op_valid` seen in any state other than IDLE is ignored; it is not queued.

## Timing

- Reset values: `op_ready`=0 while reset is asserted, and 1 in the first cycle after deassertion. All other outputs are 0. FSM=IDLE, iteration counter=0.
- Single-cycle ops:
  - accept at edge N; `pop_alu` is high during cycle N..N+1; back in IDLE with `op_ready`=1 after edge N+1.
- MUL/DIVU:
  - accept at edge N; ITER spans edges N+1..N+32; `pop_alu` is high in the cycle after edge N+32.
  - Accept-to-writeback latency is 33 cycles.
- Error path: `error` is high in the cycle after the accept edge; IDLE follows on the next edge.
- Back-to-back ops: minimum accept spacing is 2 cycles (single-cycle op) or 34 cycles (MUL/DIVU).
- `busy` is high from the cycle after accept through the WB/ERR cycle inclusive.
- Reset asserted mid-ITER or mid-WB: immediate return to IDLE.
  - Any pending `pop_alu` is suppressed and partial results are discarded.

## Configuration

- `STACK_ALU_MULDIV_EN` defined: ops 6/7 are implemented as described, including the ITER state and iteration datapath.
- Not defined:
  - ITER logic is not built.
  - Ops 6/7 go to ERR with `err_code`=3, and no `pop_alu` is issued.
  - All other behaviour is identical.

## Test plan

- ADD: `depth`=2, a=7, b=5, op 0 → `pop_alu` one cycle after accept with `result`=12, `error`=0.
- SUB/SLT: a=3, b=0xFFFFFFFE.
  - SUB → `result`=0xFFFFFFFB.
  - SLT → `result`=1.
- MUL: a=6, b=7 → `pop_alu` exactly 33 cycles after accept with `result`=42.
  - a=b=0x10000 → `result`=0.
  - Without `STACK_ALU_MULDIV_EN` → `err_code`=3 and no `pop_alu`.
- DIVU: b=100, a=7 → `result`=14.
  - a=0 → `result`=0xFFFFFFFF with `pop_alu`, `error` pulse, `err_code`=2.
- Underflow: `depth`=1, op 0 → `error` pulse, `err_code`=1, `pop_alu` never asserted, `op_ready` back to 1 two cycles after accept.
- Reset low at iteration 10 of MUL → all outputs 0 immediately, no `pop_alu`. The next ADD after release completes normally.
